sum_acc: RTL
============

SUM_ACC -- requirements
Module: sum_acc

Interface
REQ-001 SHALL have parameter COUNT, default 4, meaning the number of sums accumulated per frame (legal range 1..255).
REQ-002 SHALL have parameter ACC_W, default 36, meaning the accumulator and result width (legal range 33..64).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clr  input  1  synchronous frame abort.
REQ-006 SHALL have port in_data  input  33  unsigned sum from the upstream 32-bit adder stage (bit 32 = carry).
REQ-007 SHALL have port in_valid  input  1  in_data is valid.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 SHALL have port out_data  output  ACC_W  frame total.
REQ-010 SHALL have port out_ovf  output  1  frame total exceeded ACC_W bits.
REQ-011 SHALL have port out_valid  output  1  out_data/out_ovf valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.

Function
REQ-013 SHALL implement states IDLE, ACCUM, HOLD; a transfer SHALL occur only on a cycle with in_valid=1 and in_ready=1.
REQ-014 SHALL drive in_ready=1 in IDLE and ACCUM, and 0 in HOLD.
REQ-015 SHALL, in IDLE on a transfer, load acc=zero-extended in_data, count=1, ovf=0, and go to ACCUM (or to HOLD if COUNT=1).
REQ-016 SHALL, in ACCUM on a transfer, set acc=acc+in_data and count=count+1, going to HOLD when the new count equals COUNT.
REQ-017 SHALL hold acc, count and state unchanged on cycles without a transfer.
REQ-018 SHALL assert out_valid=1 from the cycle after the COUNT-th transfer, i.e. latency of one clock, and while in HOLD only.
REQ-019 SHALL keep out_data and out_ovf stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, in HOLD with out_ready=1, return to IDLE on the next edge; in_ready SHALL remain 0 during that cycle.
REQ-021 SHALL detect overflow as a carry out of bit ACC_W-1 on any addition and set ovf sticky for the rest of the frame.
REQ-022 SHALL, on clr=1, go to IDLE with acc=0, count=0, ovf=0, discarding any transfer or result on that cycle; clr SHALL take priority over all other inputs.
REQ-023 SHALL drive out_data=acc and out_ovf=ovf directly from registers, with no combinational path from in_* to out_*.

Reset
REQ-024 SHALL, on rst_n=0, immediately force state=IDLE, acc=0, count=0, ovf=0, out_valid=0, and in_ready=1 (after reset release), regardless of clk.
REQ-025 SHALL, on reset mid-frame or in HOLD, discard the partial or pending result with no out_valid pulse afterwards.
REQ-026 SHALL treat reset deassertion as asynchronous assert/synchronous-free release; the first transfer SHALL be possible on the first rising edge after rst_n=1.

Configuration
REQ-027 SHALL, with macro SUM_ACC_SAT_EN defined, saturate acc at 2^ACC_W-1 on overflow (later additions SHALL keep it saturated) and set ovf.
REQ-028 SHALL, without SUM_ACC_SAT_EN, wrap acc modulo 2^ACC_W on overflow and set ovf.

Verification
REQ-029 SHALL cover the basic frame: COUNT=4 with inputs 1,2,3,4 back-to-back -> out_valid one cycle after the 4th transfer, out_data=10, out_ovf=0.
REQ-030 SHALL cover backpressure: the frame completes with out_ready=0 for 5 cycles -> out_data stable for 5 cycles, in_ready=0, and IDLE after out_ready=1.
REQ-031 SHALL cover overflow with ACC_W=33: inputs 0x1_FFFF_FFFF then 0x2 -> without the macro out_data=0x1, ovf=1; with SUM_ACC_SAT_EN out_data=0x1_FFFF_FFFF, ovf=1.
REQ-032 SHALL cover clr: after 2 of 4 transfers assert clr coincident with in_valid -> no result; the next 4 inputs 5,5,5,5 -> out_data=20.
REQ-033 SHALL cover async reset: rst_n low between edges in HOLD -> out_valid drops immediately, with no result after release.
REQ-034 SHALL cover COUNT=1 with gapped in_valid: input 0x1_0000_0000 -> out_data=0x1_0000_0000 one cycle later; idle cycles do not advance count.

Source files
------------

// File: rtl/sum_acc.sv
// Frame accumulator: adds COUNT upstream 33-bit sums and holds the total until the result is accepted downstream.
// Define SUM_ACC_SAT_EN to saturate on overflow; the default build wraps on overflow.
module sum_acc #(
  parameter int COUNT = 4,
  parameter int ACC_W = 36
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [32:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [7:0] COUNT_L = 8'(COUNT);

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [7:0]       count_reg, count_next;
  logic             ovf_reg, ovf_next;

  logic [ACC_W-1:0] in_ext;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_add;
  logic [7:0]       count_inc;
  logic             carry;
  logic             xfer;

  assign in_ext    = ACC_W'(in_data);
  assign sum       = {1'b0, acc_reg} + {1'b0, in_ext};
  assign carry     = sum[ACC_W];
  assign count_inc = count_reg + 8'd1;
  assign in_ready  = (state_reg != HOLD);
  assign xfer      = in_valid && in_ready;

`ifdef SUM_ACC_SAT_EN
  // Once saturated, ovf_reg is set, so the accumulator stays pinned at all-ones.
  assign acc_add = (carry || ovf_reg) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_add = sum[ACC_W-1:0];
`endif

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;
    if (clr) begin
      state_next = IDLE;
      acc_next   = '0;
      count_next = '0;
      ovf_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (xfer) begin
            acc_next   = in_ext;
            count_next = 8'd1;
            ovf_next   = 1'b0;
            state_next = (COUNT_L == 8'd1) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc_next   = acc_add;
            count_next = count_inc;
            ovf_next   = ovf_reg | carry;
            if (count_inc == COUNT_L) state_next = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign out_data  = acc_reg;
  assign out_ovf   = ovf_reg;
  assign out_valid = (state_reg == HOLD);

endmodule
